// File: rtl/kernel_dispatcher_if.sv
// Kernel dispatcher bus: launch control, latched config,
// per-core run/reset handshake and status.
interface kernel_dispatcher_if #(
   parameter int NUM_CORES  = 4,
   parameter int DATA_WIDTH = 32
);
   logic                            start;
   logic                            abort;
   logic [DATA_WIDTH-1:0]           base_instr;
   logic [DATA_WIDTH-1:0]           base_data;
   logic [DATA_WIDTH-1:0]           num_blocks;
   logic [DATA_WIDTH-1:0]           warps_per_block;
   logic [DATA_WIDTH-1:0]           cfg_base_instr;
   logic [DATA_WIDTH-1:0]           cfg_base_data;
   logic [DATA_WIDTH-1:0]           cfg_num_blocks;
   logic [DATA_WIDTH-1:0]           cfg_warps_per_block;
   logic [NUM_CORES-1:0]            core_done;
   logic [NUM_CORES-1:0]            core_start;
   logic [NUM_CORES-1:0]            core_reset;
   logic [NUM_CORES*DATA_WIDTH-1:0] core_block_id;
   logic [DATA_WIDTH-1:0]           blocks_dispatched;
   logic [DATA_WIDTH-1:0]           blocks_completed;
   logic                            busy;
   logic                            done;
   logic                            aborted;

   modport master (
      output start, abort, base_instr, base_data, num_blocks,
      output warps_per_block, core_done,
      input  cfg_base_instr, cfg_base_data, cfg_num_blocks,
      input  cfg_warps_per_block, core_start, core_reset,
      input  core_block_id, blocks_dispatched, blocks_completed,
      input  busy, done, aborted
   );

   modport slave (
      input  start, abort, base_instr, base_data, num_blocks,
      input  warps_per_block, core_done,
      output cfg_base_instr, cfg_base_data, cfg_num_blocks,
      output cfg_warps_per_block, core_start, core_reset,
      output core_block_id, blocks_dispatched, blocks_completed,
      output busy, done, aborted
   );
endinterface

// File: rtl/kernel_dispatcher.sv
// Multi-core kernel dispatcher: latches a launch, deals block IDs
// round-robin to idle cores, re-arms cores and tracks completion.
module kernel_dispatcher #(
   parameter int NUM_CORES    = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int RESET_CYCLES = 2
) (
   input logic clk,
   input logic reset,
   kernel_dispatcher_if.slave bus
);
   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam logic [CW-1:0] RC_LOAD = CW'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, ABORTING, DONE} state_t;
   typedef enum logic [1:0] {C_IDLE, C_RESET, C_RUN} cstate_t;

   state_t                state_q;
   cstate_t               cst_q [NUM_CORES];
   logic [CW-1:0]         cnt_q [NUM_CORES];
   logic [DATA_WIDTH-1:0] bid_q [NUM_CORES];
   logic [NUM_CORES-1:0]  cstart_q;
   logic [NUM_CORES-1:0]  creset_q;
   logic [DATA_WIDTH-1:0] cfg_instr_q;
   logic [DATA_WIDTH-1:0] cfg_data_q;
   logic [DATA_WIDTH-1:0] cfg_num_q;
   logic [DATA_WIDTH-1:0] cfg_warps_q;
   logic [DATA_WIDTH-1:0] disp_q;
   logic [DATA_WIDTH-1:0] cmpl_q;
   logic [PW-1:0]         rr_q;
   logic                  start_prev_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  aborted_q;

   logic                  launch;
   logic [DATA_WIDTH-1:0] pop_d;
   logic [DATA_WIDTH-1:0] cmpl_d;
   logic                  sel_vld_d;
   logic [PW-1:0]         sel_d;
   logic [PW-1:0]         rr_d;
   logic                  disp_go;

   assign launch = bus.start & ~start_prev_q;

   // Completion popcount and round-robin search for a free core
   always_comb begin
      int idx;
      idx       = 0;
      pop_d     = '0;
      sel_vld_d = 1'b0;
      sel_d     = '0;
      for (int i = 0; i < NUM_CORES; i++)
         if (cst_q[i] == C_RUN && bus.core_done[i])
            pop_d = pop_d + DATA_WIDTH'(1);
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = (int'(rr_q) + k) % NUM_CORES;
         if (!sel_vld_d && cst_q[idx] == C_IDLE) begin
            sel_vld_d = 1'b1;
            sel_d     = PW'(idx);
         end
      end
      cmpl_d = cmpl_q + pop_d;
      rr_d   = (int'(sel_d) + 1 == NUM_CORES) ? '0 : sel_d + PW'(1);
   end

   assign disp_go = (state_q == RUN) && !bus.abort &&
                    (disp_q < cfg_num_q) && sel_vld_d;

   // Launch FSM plus per-core re-arm FSMs; later writes take priority
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cstart_q     <= '0;
         creset_q     <= '0;
         cfg_instr_q  <= '0;
         cfg_data_q   <= '0;
         cfg_num_q    <= '0;
         cfg_warps_q  <= '0;
         disp_q       <= '0;
         cmpl_q       <= '0;
         rr_q         <= '0;
         start_prev_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) begin
            cst_q[i] <= C_IDLE;
            cnt_q[i] <= '0;
            bid_q[i] <= '0;
         end
      end else begin
         start_prev_q <= bus.start;
         for (int i = 0; i < NUM_CORES; i++) begin
            unique case (cst_q[i])
               C_RESET: begin
                  if (cnt_q[i] == '0) begin
                     cst_q[i]    <= C_IDLE;
                     creset_q[i] <= 1'b0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] - CW'(1);
                  end
               end
               C_RUN: begin
                  if (bus.core_done[i]) begin
                     cst_q[i]    <= C_RESET;
                     cnt_q[i]    <= RC_LOAD;
                     cstart_q[i] <= 1'b0;
                     creset_q[i] <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
         unique case (state_q)
            IDLE, DONE: begin
               if (launch) begin
                  cfg_instr_q <= bus.base_instr;
                  cfg_data_q  <= bus.base_data;
                  cfg_num_q   <= bus.num_blocks;
                  cfg_warps_q <= bus.warps_per_block;
                  disp_q      <= '0;
                  cmpl_q      <= '0;
                  aborted_q   <= 1'b0;
                  rr_q        <= '0;
                  if (bus.num_blocks == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= RUN;
                     busy_q   <= 1'b1;
                     done_q   <= 1'b0;
                     cstart_q <= '0;
                     creset_q <= '1;
                     for (int i = 0; i < NUM_CORES; i++) begin
                        cst_q[i] <= C_RESET;
                        cnt_q[i] <= RC_LOAD;
                     end
                  end
               end
            end
            RUN: begin
               cmpl_q <= cmpl_d;
               if (bus.abort) begin
                  state_q  <= ABORTING;
                  cstart_q <= '0;
                  creset_q <= '1;
                  for (int i = 0; i < NUM_CORES; i++) begin
                     cst_q[i] <= C_RESET;
                     cnt_q[i] <= RC_LOAD;
                  end
               end else if (cmpl_d == cfg_num_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
               if (disp_go) begin
                  cst_q[sel_d]    <= C_RUN;
                  cstart_q[sel_d] <= 1'b1;
                  bid_q[sel_d]    <= disp_q;
                  disp_q          <= disp_q + DATA_WIDTH'(1);
                  rr_q            <= rr_d;
               end
            end
            ABORTING: begin
               if (cnt_q[0] == '0) begin
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cfg_base_instr      = cfg_instr_q;
   assign bus.cfg_base_data       = cfg_data_q;
   assign bus.cfg_num_blocks      = cfg_num_q;
   assign bus.cfg_warps_per_block = cfg_warps_q;
   assign bus.core_start          = cstart_q;
   assign bus.core_reset          = creset_q;
   assign bus.blocks_dispatched   = disp_q;
   assign bus.blocks_completed    = cmpl_q;
   assign bus.busy                = busy_q;
   assign bus.done                = done_q;
   assign bus.aborted             = aborted_q;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_bid
      assign bus.core_block_id[g*DATA_WIDTH +: DATA_WIDTH] = bid_q[g];
   end
endmodule

// File: tb/tb_kernel_dispatcher.sv
// Directed bench for kernel_dispatcher with a simple
// auto-completing core model and per-ID dispatch log.
module tb_kernel_dispatcher;
   localparam int NC = 4;
   localparam int DW = 32;
   localparam int RC = 2;

   logic clk;
   logic reset;
   int   nvec;
   int   nerr;
   int   cyc;
   bit   auto_en;
   int   rcnt [NC];
   bit   prev [NC];
   int   issue_cnt [16];
   int   issue_core [16];
   int   issue_cyc [16];

   kernel_dispatcher_if #(.NUM_CORES(NC), .DATA_WIDTH(DW)) bus ();

   kernel_dispatcher #(
      .NUM_CORES(NC), .DATA_WIDTH(DW), .RESET_CYCLES(RC)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_log();
      for (int k = 0; k < 16; k++) begin
         issue_cnt[k]  = 0;
         issue_core[k] = -1;
         issue_cyc[k]  = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NC; i++) begin
         bit s;
         int id;
         s  = bus.core_start[i];
         id = int'(bus.core_block_id[i*DW +: DW]);
         if (s && !prev[i] && id < 16) begin
            issue_cnt[id]++;
            issue_core[id] = i;
            issue_cyc[id]  = cyc;
         end
         if (auto_en) begin
            if (s) rcnt[i]++;
            else rcnt[i] = 0;
            bus.core_done[i] = s && (rcnt[i] >= 10);
         end
         prev[i] = s;
      end
   endtask

   task automatic launch();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!bus.done && n < lim) begin
         step();
         n++;
      end
      chk("done_wait", bus.done, 1);
   endtask

   task automatic wait_disp(input int v, input int lim);
      int n;
      n = 0;
      while (int'(bus.blocks_dispatched) != v && n < lim) begin
         step();
         n++;
      end
      chk("disp_wait", bus.blocks_dispatched, v);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      cyc  = 0;
      auto_en = 0;
      for (int i = 0; i < NC; i++) begin
         rcnt[i] = 0;
         prev[i] = 0;
      end
      clr_log();
      reset = 1'b1;
      bus.start = 0;
      bus.abort = 0;
      bus.base_instr = 0;
      bus.base_data = 0;
      bus.num_blocks = 0;
      bus.warps_per_block = 0;
      bus.core_done = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start", bus.core_start, 0);
      chk("rst_reset", bus.core_reset, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cfgnum", bus.cfg_num_blocks, 0);
      reset = 1'b0;
      step();

      // zero-block launch
      bus.num_blocks = 0;
      bus.base_instr = 32'h100;
      launch();
      chk("z_done", bus.done, 1);
      chk("z_busy", bus.busy, 0);
      chk("z_cinst", bus.cfg_base_instr, 32'h100);
      chk("z_reset", bus.core_reset, 0);
      step();
      chk("z_reset2", bus.core_reset, 0);
      chk("z_start2", bus.core_start, 0);
      chk("z_cmpl", bus.blocks_completed, 0);

      // six blocks, auto-completing cores
      clr_log();
      auto_en = 1;
      bus.num_blocks = 6;
      bus.warps_per_block = 3;
      launch();
      chk("b6_done0", bus.done, 0);
      chk("b6_busy", bus.busy, 1);
      wait_done(200);
      chk("b6_cmpl", bus.blocks_completed, 6);
      chk("b6_disp", bus.blocks_dispatched, 6);
      chk("b6_busy_end", bus.busy, 0);
      chk("b6_abrt", bus.aborted, 0);
      for (int k = 0; k < 6; k++)
         chk($sformatf("b6_id%0d_cnt", k), issue_cnt[k], 1);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("b6_id%0d_core", k), issue_core[k], k);
         chk($sformatf("b6_id%0d_dly", k),
             issue_cyc[k] - issue_cyc[0], k);
      end
      chk("b6_id0_core", issue_core[0], 0);
      chk("b6_id4_core", issue_core[4], 0);
      chk("b6_id5_core", issue_core[5], 1);
      repeat (4) step();

      // simultaneous completion on cores 1 and 2
      auto_en = 0;
      bus.core_done = 0;
      bus.num_blocks = 4;
      launch();
      chk("lat_rst0", bus.core_reset, 4'hf);
      step();
      chk("lat_rst1", bus.core_reset, 4'hf);
      step();
      chk("lat_rst2", bus.core_reset, 4'h0);
      chk("lat_st2", bus.core_start, 4'h0);
      step();
      chk("lat_st3", bus.core_start, 4'h1);
      chk("lat_id0", bus.core_block_id[0 +: DW], 0);
      wait_disp(4, 20);
      chk("p_start", bus.core_start, 4'hf);
      bus.core_done = 4'b0110;
      step();
      bus.core_done = 0;
      chk("p_cmpl", bus.blocks_completed, 2);
      chk("p_rst1", bus.core_reset, 4'b0110);
      chk("p_st1", bus.core_start, 4'b1001);
      step();
      chk("p_rst2", bus.core_reset, 4'b0110);
      step();
      chk("p_rst3", bus.core_reset, 4'b0000);
      chk("p_st3", bus.core_start, 4'b1001);
      bus.core_done = 4'b1001;
      step();
      bus.core_done = 0;
      chk("p_cmpl4", bus.blocks_completed, 4);
      chk("p_done", bus.done, 1);
      repeat (3) step();

      // abort with three blocks in flight
      bus.num_blocks = 8;
      launch();
      wait_disp(3, 20);
      chk("a_start", bus.core_start, 4'b0111);
      bus.abort = 1;
      step();
      bus.abort = 0;
      chk("a_st1", bus.core_start, 0);
      chk("a_rst1", bus.core_reset, 4'hf);
      chk("a_disp", bus.blocks_dispatched, 3);
      chk("a_busy1", bus.busy, 1);
      step();
      chk("a_rst2", bus.core_reset, 4'hf);
      chk("a_done2", bus.done, 0);
      step();
      chk("a_rst3", bus.core_reset, 0);
      chk("a_done", bus.done, 1);
      chk("a_abrt", bus.aborted, 1);
      chk("a_busy", bus.busy, 0);
      bus.abort = 1;
      step();
      bus.abort = 0;
      chk("a_ign", bus.core_reset, 0);

      // mid-run input changes and spurious start
      auto_en = 1;
      bus.base_data = 32'hA000;
      bus.num_blocks = 5;
      launch();
      chk("m_abclr", bus.aborted, 0);
      repeat (3) step();
      bus.base_data = 32'hB000;
      bus.num_blocks = 2;
      bus.start = 1;
      step();
      bus.start = 0;
      step();
      chk("m_cdata", bus.cfg_base_data, 32'hA000);
      chk("m_cnum", bus.cfg_num_blocks, 5);
      chk("m_busy", bus.busy, 1);
      wait_done(300);
      chk("m_cmpl", bus.blocks_completed, 5);
      launch();
      chk("m2_done", bus.done, 0);
      chk("m2_cnum", bus.cfg_num_blocks, 2);
      chk("m2_cdata", bus.cfg_base_data, 32'hB000);
      chk("m2_cmpl0", bus.blocks_completed, 0);
      wait_done(200);
      chk("m2_cmpl", bus.blocks_completed, 2);

      // asynchronous reset mid-run
      bus.num_blocks = 6;
      launch();
      repeat (6) step();
      chk("r_busy0", bus.busy, 1);
      #2;
      reset = 1;
      #1;
      chk("r_start", bus.core_start, 0);
      chk("r_busy", bus.busy, 0);
      chk("r_disp", bus.blocks_dispatched, 0);
      chk("r_cnum", bus.cfg_num_blocks, 0);
      @(posedge clk);
      #1;
      reset = 0;
      bus.core_done = 0;
      for (int i = 0; i < NC; i++) begin
         rcnt[i] = 0;
         prev[i] = 0;
      end
      step();
      chk("r_idle_busy", bus.busy, 0);
      chk("r_idle_done", bus.done, 0);
      bus.num_blocks = 2;
      launch();
      wait_done(200);
      chk("r_cmpl", bus.blocks_completed, 2);
      chk("r_abrt", bus.aborted, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
